// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver and decoder.
// Synchronizes the raw PS/2 pins and deframes 11-bit frames, checking start,
// odd parity and stop, with a mid-frame timeout. Make codes for the arrow
// keys and Space become single-cycle pulses. E0/F0 prefixes and break
// sequences are tracked, and break sequences never produce a key pulse.
module ps2_keyboard #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       kup,
    output logic       kdown,
    output logic       kleft,
    output logic       kright,
    output logic       pause,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic [1:0]    state;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic [8:0]    shreg;
    logic          ext;
    logic          brk;

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall;
    logic bit_in;

    // Two-stage synchronizers for both pins plus the edge-detect register
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    // Falling edge of the synchronized PS/2 clock and the data bit sampled with it
    always_comb begin
        fall   = clk_prev & ~clk_s2;
        bit_in = dat_s2;
    end

    // Frame FSM, timeout, prefix tracking and key decode
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            shreg       <= '0;
            ext         <= 1'b0;
            brk         <= 1'b0;
            scan_code   <= '0;
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
            kup         <= 1'b0;
            kdown       <= 1'b0;
            kleft       <= 1'b0;
            kright      <= 1'b0;
            pause       <= 1'b0;
        end else begin
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
            kup         <= 1'b0;
            kdown       <= 1'b0;
            kleft       <= 1'b0;
            kright      <= 1'b0;
            pause       <= 1'b0;

            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (fall && !bit_in) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end

                SHIFT: begin
                    if (fall) begin
                        to_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            // The frame is judged on the stop-bit edge itself so the
                            // result pulses are registered in the CHECK cycle.
                            state   <= CHECK;
                            bit_cnt <= '0;
                            if (bit_in && (^shreg)) begin
                                scan_code  <= shreg[7:0];
                                code_valid <= 1'b1;
                                if (shreg[7:0] == 8'hE0) begin
                                    ext <= 1'b1;
                                end else if (shreg[7:0] == 8'hF0) begin
                                    brk <= 1'b1;
                                end else begin
                                    if (!brk) begin
                                        if (ext) begin
                                            case (shreg[7:0])
                                                8'h75:   kup    <= 1'b1;
                                                8'h72:   kdown  <= 1'b1;
                                                8'h6B:   kleft  <= 1'b1;
                                                8'h74:   kright <= 1'b1;
                                                default: ;
                                            endcase
                                        end else if (shreg[7:0] == 8'h29) begin
                                            pause <= 1'b1;
                                        end
                                    end
                                    ext <= 1'b0;
                                    brk <= 1'b0;
                                end
                            end else begin
                                frame_error <= 1'b1;
                                ext         <= 1'b0;
                                brk         <= 1'b0;
                            end
                        end else begin
                            shreg   <= {bit_in, shreg[8:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
                        state       <= IDLE;
                        bit_cnt     <= '0;
                        to_cnt      <= '0;
                        frame_error <= 1'b1;
                        ext         <= 1'b0;
                        brk         <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                CHECK: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed testbench for ps2_keyboard with an event scoreboard.
// Every cycle in which the DUT raises any pulse output is one event, recorded
// as {frame_error, code_valid, kup, kdown, kleft, kright, pause, scan_code}
// and compared against the next expected event in the queue.
module tb_ps2_keyboard;

    localparam int unsigned TO   = 1000;
    localparam int unsigned HALF = 100;

    logic       clock;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       kup, kdown, kleft, kright, pause;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_error;

    logic [14:0] sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // reference model state
    logic [7:0] m_last = 8'h00;
    bit         m_ext  = 1'b0;
    bit         m_brk  = 1'b0;

    logic [14:0] mon_obs;
    logic [14:0] mon_exp;

    ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .kup         (kup),
        .kdown       (kdown),
        .kleft       (kleft),
        .kright      (kright),
        .pause       (pause),
        .scan_code   (scan_code),
        .code_valid  (code_valid),
        .frame_error (frame_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard consumer: one comparison per DUT output event
    always @(negedge clock) begin
        if (!reset && (frame_error || code_valid || kup || kdown || kleft || kright || pause)) begin
            mon_obs = {frame_error, code_valid, kup, kdown, kleft, kright, pause, scan_code};
            if (sb.size() > 0) mon_exp = sb.pop_front();
            else               mon_exp = 'x;
            n_cmp++;
            assert (mon_obs === mon_exp)
            else begin
                n_bad++;
                $error("FAIL event obs=%h exp=%h", mon_obs, mon_exp);
            end
        end
    end

    // Expected event for a correctly received byte
    task automatic expect_good(input logic [7:0] b);
        logic [4:0] keys;
        keys   = 5'b0;
        m_last = b;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!m_brk) begin
                if (m_ext && b == 8'h75)       keys = 5'b10000;
                else if (m_ext && b == 8'h72)  keys = 5'b01000;
                else if (m_ext && b == 8'h6B)  keys = 5'b00100;
                else if (m_ext && b == 8'h74)  keys = 5'b00010;
                else if (!m_ext && b == 8'h29) keys = 5'b00001;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        sb.push_back({1'b0, 1'b1, keys, b});
    endtask

    // Expected event for a discarded frame (scan_code must keep its old value)
    task automatic expect_error();
        m_ext = 1'b0;
        m_brk = 1'b0;
        sb.push_back({1'b1, 1'b0, 5'b0, m_last});
    endtask

    // Drive the first nbits bits of a frame (start, 8 data LSB first, parity, stop)
    task automatic send(input logic [7:0] b, input bit flip_par, input int unsigned nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (4 * HALF) @(negedge clock);
    endtask

    task automatic send_good(input logic [7:0] b);
        expect_good(b);
        send(b, 1'b0, 11);
    endtask

    // Wait (bounded) for all expected events, then allow time for stray pulses
    task automatic drain(input string tag, input int unsigned limit);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        repeat (20) @(negedge clock);
        n_cmp++;
        assert (sb.size() === 0)
        else begin
            n_bad++;
            $error("FAIL %s pending=%0d exp=0", tag, sb.size());
        end
        sb.delete();
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        n_cmp++;
        assert ({frame_error, code_valid, kup, kdown, kleft, kright, pause, scan_code} === 15'h0)
        else begin
            n_bad++;
            $error("FAIL reset_state obs=%h exp=0", {frame_error, code_valid, kup, kdown, kleft, kright, pause, scan_code});
        end

        // Up make
        send_good(8'hE0);
        send_good(8'h75);
        drain("up_make", 200);

        // Up break, then Left make
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        send_good(8'hE0);
        send_good(8'h6B);
        drain("break_then_left", 200);

        // Space, then 75 without prefix, then typematic Space repeat
        send_good(8'h29);
        send_good(8'h75);
        send_good(8'h29);
        drain("pause_plain75", 200);

        // Parity error, then Down make
        expect_error();
        send(8'h72, 1'b1, 11);
        send_good(8'hE0);
        send_good(8'h72);
        drain("parity_then_down", 200);

        // Timeout after a partial frame, then Right make
        send_good(8'hE0);
        send(8'h75, 1'b0, 5);
        expect_error();
        drain("timeout", 3 * TO);
        send_good(8'hE0);
        send_good(8'h74);
        drain("right_after_timeout", 200);

        // Reset in the middle of a frame (after bit 4)
        send(8'h29, 1'b0, 6);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset  = 1'b0;
        m_last = 8'h00;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        @(negedge clock);
        n_cmp++;
        assert ({frame_error, code_valid, kup, kdown, kleft, kright, pause, scan_code} === 15'h0)
        else begin
            n_bad++;
            $error("FAIL midframe_reset obs=%h exp=0", {frame_error, code_valid, kup, kdown, kleft, kright, pause, scan_code});
        end
        send_good(8'hE0);
        send_good(8'h75);
        drain("up_after_reset", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
